mskand_hpc3o_sched: RTL and testbench

- Round-robin scheduler that time-shares one MSKand_hpc3o-type masked AND gadget (latency 1, needs ina_prev) among NREQ requesters.
- Per operation it consumes one fresh randomness word from the PRNG, generates the one-cycle-delayed ina_prev copy, and returns the tagged result through a 2-entry response FIFO with valid/ready.
- Sits between masked-datapath clients and a single shared AND gadget instantiated at the parent level.

---
 rtl/mskand_hpc3o_sched.sv | 167 ++++++++++++++++
 tb/tb_mskand_hpc3o_sched.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mskand_hpc3o_sched.sv
// Round-robin scheduler sharing one latency-1 masked AND gadget (HPC3o type)
// among NREQ requesters. Each issued operation consumes one randomness word,
// produces the one-cycle-delayed ina_prev copy for the gadget, and returns the
// tagged result through a 2-entry in-order response FIFO.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      per-requester request / one-hot grant
//   req_a, req_b             packed sharings, requester k at [k*d +: d]
//   rnd_valid/rnd_ready/rnd_in  PRNG word handshake
//   g_ina, g_inb, g_ina_prev, g_rnd, g_out   shared gadget interface
//   rsp_valid/rsp_ready, rsp_id, rsp_out     response FIFO head

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module mskand_hpc3o_sched #(
    parameter int unsigned d    = `DEFAULTSHARES,
    parameter int unsigned NREQ = 4,
    parameter int unsigned RNDW = d * (d - 1),
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*d-1:0]   req_a,
    input  logic [NREQ*d-1:0]   req_b,
    input  logic                rnd_valid,
    output logic                rnd_ready,
    input  logic [RNDW-1:0]     rnd_in,
    output logic [d-1:0]        g_ina,
    output logic [d-1:0]        g_inb,
    output logic [d-1:0]        g_ina_prev,
    output logic [RNDW-1:0]     g_rnd,
    input  logic [d-1:0]        g_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [d-1:0]        rsp_out
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           s1_valid_q;
    logic [IDW-1:0] s1_id_q;
    logic [d-1:0]   s1_a_q;

    logic [1:0]     count_q;
    logic [IDW-1:0] ent_id_q  [2];
    logic [d-1:0]   ent_out_q [2];

    logic           found;
    logic [IDW-1:0] grant;
    int unsigned    idx;
    logic           rsp_fire;
    logic [2:0]     occ;
    logic           issue;
    logic           push;

    assign rsp_fire = rsp_valid & rsp_ready;
    // Slots committed for future responses: FIFO entries plus the op in S1.
    assign occ      = 3'(count_q) + 3'(s1_valid_q);
    assign issue    = !rst && (|req_valid) && rnd_valid && (occ < (3'd2 + 3'(rsp_fire)));
    assign push     = s1_valid_q;

    // First valid requester scanning from ptr upward, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        rnd_ready = 1'b0;
        g_ina     = '0;
        g_inb     = '0;
        g_rnd     = '0;
        ptr_d     = ptr_q;
        if (issue) begin
            req_ready[grant] = 1'b1;
            rnd_ready        = 1'b1;
            g_ina            = req_a[32'(grant) * d +: d];
            g_inb            = req_b[32'(grant) * d +: d];
            g_rnd            = rnd_in;
            ptr_d            = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    assign g_ina_prev = s1_a_q;
    assign rsp_valid  = (count_q != 2'd0);
    assign rsp_id     = ent_id_q[0];
    assign rsp_out    = ent_out_q[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= issue;
            s1_id_q    <= issue ? grant : '0;
            s1_a_q     <= issue ? g_ina : '0;
        end
    end

    // Head lives in entry 0; a pop shifts entry 1 down.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                ent_id_q[i]  <= '0;
                ent_out_q[i] <= '0;
            end
        end else begin
            case ({push, rsp_fire})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent_id_q[0]  <= s1_id_q;
                        ent_out_q[0] <= g_out;
                    end else begin
                        ent_id_q[1]  <= s1_id_q;
                        ent_out_q[1] <= g_out;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    ent_id_q[0]  <= ent_id_q[1];
                    ent_out_q[0] <= ent_out_q[1];
                    ent_id_q[1]  <= '0;
                    ent_out_q[1] <= '0;
                    count_q      <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        ent_id_q[0]  <= s1_id_q;
                        ent_out_q[0] <= g_out;
                    end else begin
                        ent_id_q[0]  <= ent_id_q[1];
                        ent_out_q[0] <= ent_out_q[1];
                        ent_id_q[1]  <= s1_id_q;
                        ent_out_q[1] <= g_out;
                    end
                end
                default: ;
            endcase
        end
    end

    // The issue rule reserves space, so a push into a full FIFO is a design bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && !rsp_fire && count_q == 2'd2));
        end
    end

endmodule

// File: tb/tb_mskand_hpc3o_sched.sv
module tb_mskand_hpc3o_sched;

    localparam int D    = 2;
    localparam int NREQ = 4;
    localparam int RNDW = 2;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*D-1:0] req_a;
    logic [NREQ*D-1:0] req_b;
    logic              rnd_valid;
    logic              rnd_ready;
    logic [RNDW-1:0]   rnd_in;
    logic [D-1:0]      g_ina;
    logic [D-1:0]      g_inb;
    logic [D-1:0]      g_ina_prev;
    logic [RNDW-1:0]   g_rnd;
    logic [D-1:0]      g_out;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [D-1:0]      rsp_out;

    mskand_hpc3o_sched #(
        .d    (D),
        .NREQ (NREQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_in     (rnd_in),
        .g_ina      (g_ina),
        .g_inb      (g_inb),
        .g_ina_prev (g_ina_prev),
        .g_rnd      (g_rnd),
        .g_out      (g_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in gadget: latency 1, output sharing XORs to (^ina) & (^inb).
    always @(posedge clk) begin
        g_out <= {((^g_ina) & (^g_inb)) ^ g_rnd[0], g_rnd[0]};
    end

    typedef struct {
        int id;
        bit par;
        int avail;
    } ent_t;

    ent_t       exp_q[$];
    int         ptr_m;
    logic [1:0] prev_a_m;
    int         cyc;
    int         issues_m;
    int         rnd_pulses;
    bit         chk_en;
    logic [1:0] a_r [NREQ];
    logic [1:0] b_r [NREQ];
    int         tests_run;
    int         tests_failed;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic run_cycle(input logic [3:0] rv, input bit rndv, input bit rspr, input bit rstv);
        bit         head_ok;
        bit         fire;
        bit         issue;
        bit         found;
        int         g;
        logic [3:0] exp_rr;
        logic [1:0] ea;
        logic [1:0] eb;
        logic [1:0] er;
        @(posedge clk);
        #1;
        rst       = rstv;
        req_valid = rv;
        rnd_valid = rndv;
        rsp_ready = rspr;
        rnd_in    = 2'($urandom);
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*D +: D] = a_r[k];
            req_b[k*D +: D] = b_r[k];
        end
        #3;
        if (chk_en) begin
            head_ok = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
            fire    = head_ok && rspr;
            check_eq("rsp_valid", 32'(rsp_valid), 32'(head_ok));
            if (head_ok) begin
                check_eq("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                check_eq("rsp_parity", 32'(^rsp_out), 32'(exp_q[0].par));
            end
            check_eq("g_ina_prev", 32'(g_ina_prev), 32'(prev_a_m));
            issue  = !rstv && (rv != 4'b0) && rndv && ((exp_q.size() - int'(fire)) < 2);
            g      = 0;
            found  = 1'b0;
            exp_rr = '0;
            ea     = '0;
            eb     = '0;
            er     = '0;
            if (issue) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (!found && rv[(ptr_m + i) % NREQ]) begin
                        found = 1'b1;
                        g     = (ptr_m + i) % NREQ;
                    end
                end
                exp_rr[g] = 1'b1;
                ea        = a_r[g];
                eb        = b_r[g];
                er        = rnd_in;
            end
            check_eq("req_ready", 32'(req_ready), 32'(exp_rr));
            check_eq("rnd_ready", 32'(rnd_ready), 32'(issue));
            check_eq("g_ina", 32'(g_ina), 32'(ea));
            check_eq("g_inb", 32'(g_inb), 32'(eb));
            check_eq("g_rnd", 32'(g_rnd), 32'(er));
            if (rnd_ready === 1'b1) rnd_pulses++;
            if (fire) void'(exp_q.pop_front());
            if (issue) begin
                exp_q.push_back('{g, (^ea) & (^eb), cyc + 2});
                ptr_m    = (g + 1) % NREQ;
                issues_m++;
                a_r[g]   = 2'($urandom);
                b_r[g]   = 2'($urandom);
            end
            prev_a_m = ea;
        end
        if (rstv) begin
            exp_q.delete();
            ptr_m    = 0;
            prev_a_m = '0;
            chk_en   = 1'b1;
        end
        cyc++;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        issues_m     = 0;
        rnd_pulses   = 0;
        chk_en       = 1'b0;
        ptr_m        = 0;
        prev_a_m     = '0;
        rst          = 1'b1;
        req_valid    = '0;
        rnd_valid    = 1'b0;
        rsp_ready    = 1'b0;
        rnd_in       = '0;
        req_a        = '0;
        req_b        = '0;
        for (int k = 0; k < NREQ; k++) begin
            a_r[k] = 2'($urandom);
            b_r[k] = 2'($urandom);
        end

        run_cycle(4'b0000, 1'b0, 1'b1, 1'b1);
        run_cycle(4'b0000, 1'b0, 1'b1, 1'b1);

        // Single op from requester 2 over all share combinations.
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v      = 4'(i);
            a_r[2] = v[1:0];
            b_r[2] = v[3:2];
            run_cycle(4'b0100, 1'b1, 1'b1, 1'b0);
            run_cycle(4'b0000, 1'b1, 1'b1, 1'b0);
            run_cycle(4'b0000, 1'b1, 1'b1, 1'b0);
        end

        // Fairness with all requesters valid.
        for (int i = 0; i < 12; i++) run_cycle(4'b1111, 1'b1, 1'b1, 1'b0);

        // Randomness stall mid-stream.
        for (int i = 0; i < 3; i++) run_cycle(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(4'b1111, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(4'b1111, 1'b1, 1'b1, 1'b0);

        // Backpressure then release.
        for (int i = 0; i < 6; i++) run_cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) run_cycle(4'b1111, 1'b1, 1'b1, 1'b0);

        // Reset with one entry in the FIFO and one op in flight.
        run_cycle(4'b0000, 1'b1, 1'b1, 1'b0);
        run_cycle(4'b0000, 1'b1, 1'b1, 1'b0);
        run_cycle(4'b0010, 1'b1, 1'b0, 1'b0);
        run_cycle(4'b0100, 1'b1, 1'b0, 1'b0);
        run_cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        run_cycle(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b1, 1'b1, 1'b0);

        // Pointer wrap: requester 3 then requester 0, with idle gaps.
        run_cycle(4'b1000, 1'b1, 1'b1, 1'b0);
        run_cycle(4'b0000, 1'b1, 1'b1, 1'b0);
        run_cycle(4'b0001, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(4'b0000, 1'b1, 1'b1, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            run_cycle(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 80) == 0);
        end
        for (int i = 0; i < 4; i++) run_cycle(4'b0000, 1'b1, 1'b1, 1'b0);

        check_eq("rnd_pulses_vs_ops", 32'(rnd_pulses), 32'(issues_m));
        check_eq("drained", 32'(rsp_valid), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
